// File: rtl/segre_pkg.sv
// Shared definitions for the segre memory responder.
//   CACHE_LINE_SIZE_BYTES : bytes per cache line moved on each request
//   WORD_SIZE             : width of the byte address bus
//   LINE_W                : cache line width in bits
//   mem_resp_state_e      : responder FSM states
//   mem_op_e              : operation latched on request acceptance
package segre_pkg;

  localparam int unsigned CACHE_LINE_SIZE_BYTES = 16;
  localparam int unsigned WORD_SIZE             = 32;
  localparam int unsigned LINE_W                = CACHE_LINE_SIZE_BYTES * 8;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StDone
  } mem_resp_state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } mem_op_e;

endpackage

// File: rtl/segre_mem_array.sv
// Line-wide storage for the memory responder: synchronous single-port RAM.
//   clk_i   : clock (rising edge)
//   we_i    : write enable; writes wdata_i at addr_i
//   addr_i  : line index
//   wdata_i : line to write
//   rdata_o : registered read data for addr_i (write-first: a write returns
//             the new line on the same edge)
// No reset: contents survive the responder's reset.
module segre_mem_array #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_q       <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/segre_mem_responder.sv
// Fixed-latency main-memory model answering line reads and writebacks from
// the data cache.
//   clk_i       : clock (rising edge)
//   rst_i       : asynchronous active-high reset
//   rd_i        : line-read request (sampled only in idle)
//   wr_i        : line-writeback request (sampled only in idle)
//   addr_i      : byte address of the request
//   line_i      : writeback line data
//   line_o      : read line data, held until the next read response
//   mem_ready_o : one-cycle completion pulse
//   busy_o      : high whenever the FSM is not idle
//   err_o       : out-of-range flag, pulses with mem_ready_o
// Optional feature: define SEGRE_MEM_RANGE_CHECK_EN to flag addresses beyond
// the storage (write suppressed, read returns zero). Without it the upper
// address bits wrap and err_o stays 0.
module segre_mem_responder
  import segre_pkg::*;
#(
  parameter int unsigned MEM_LATENCY    = 5,
  parameter int unsigned MEM_SIZE_LINES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  input  logic [WORD_SIZE-1:0] addr_i,
  input  logic [LINE_W-1:0]    line_i,
  output logic [LINE_W-1:0]    line_o,
  output logic                 mem_ready_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned Ofs  = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int unsigned IdxW = $clog2(MEM_SIZE_LINES);
  localparam logic [7:0]  LatLoad = 8'(MEM_LATENCY - 1);

  mem_resp_state_e   state_q;
  logic [7:0]        cnt_q;
  mem_op_e           op_q;
  logic              pend_rd_q;
  logic [IdxW-1:0]   idx_q;
  logic [LINE_W-1:0] wline_q;
  logic              oor_q;
  logic              mem_ready_q;
  logic              busy_q;
  logic              err_q;
  logic [LINE_W-1:0] line_q;

  logic [IdxW-1:0]   idx_in;
  logic              oor_in;
  logic [IdxW-1:0]   arr_addr;
  logic              arr_we;
  logic [LINE_W-1:0] arr_rdata;
  logic              resp_rd;
  logic [LINE_W-1:0] resp_line;
  logic              unused_addr;

  assign idx_in      = addr_i[IdxW+Ofs-1:Ofs];
  assign unused_addr = ^{addr_i[Ofs-1:0], addr_i[WORD_SIZE-1:IdxW+Ofs]};

`ifdef SEGRE_MEM_RANGE_CHECK_EN
  assign oor_in = |addr_i[WORD_SIZE-1:IdxW+Ofs];
`else
  assign oor_in = 1'b0;
`endif

  // In idle the array already reads the incoming index, so data is ready
  // in the response cycle even with a one-cycle latency.
  assign arr_addr  = (state_q == StIdle) ? idx_in : idx_q;
  assign arr_we    = (state_q == StResp) && (op_q == OpWrite) && !oor_q;
  assign resp_rd   = (state_q == StResp) && (op_q == OpRead);
  assign resp_line = oor_q ? '0 : arr_rdata;

  segre_mem_array #(
    .Depth(MEM_SIZE_LINES),
    .Width(LINE_W)
  ) u_mem_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .addr_i (arr_addr),
    .wdata_i(wline_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OpRead;
      pend_rd_q   <= 1'b0;
      idx_q       <= '0;
      wline_q     <= '0;
      oor_q       <= 1'b0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      line_q      <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_i || wr_i) begin
            idx_q     <= idx_in;
            op_q      <= wr_i ? OpWrite : OpRead;
            // Combined request: write first, read follows without idling.
            pend_rd_q <= rd_i && wr_i;
            wline_q   <= line_i;
            oor_q     <= oor_in;
            cnt_q     <= LatLoad;
            busy_q    <= 1'b1;
            if (MEM_LATENCY == 1) begin
              state_q     <= StResp;
              mem_ready_q <= 1'b1;
              err_q       <= oor_in;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q     <= StResp;
            mem_ready_q <= 1'b1;
            err_q       <= oor_q;
          end
        end
        StResp: begin
          if (op_q == OpRead) begin
            line_q <= resp_line;
          end
          if (pend_rd_q) begin
            pend_rd_q <= 1'b0;
            op_q      <= OpRead;
            cnt_q     <= LatLoad;
            if (MEM_LATENCY == 1) begin
              mem_ready_q <= 1'b1;
              err_q       <= oor_q;
            end else begin
              state_q <= StWait;
            end
          end else begin
            // Extra cycle lets a level-held request drop before idle.
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign line_o      = resp_rd ? resp_line : line_q;
  assign mem_ready_o = mem_ready_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_segre_mem_responder.sv
// Directed self-checking bench for segre_mem_responder (default parameters).
// Cycle 0 is the cycle a request is driven; cycle k is sampled 1 time unit
// after the k-th following rising edge.
module tb_segre_mem_responder;
  import segre_pkg::*;

  localparam logic [LINE_W-1:0] LineA5 = {CACHE_LINE_SIZE_BYTES{8'hA5}};
  localparam logic [LINE_W-1:0] Line3C = {CACHE_LINE_SIZE_BYTES{8'h3C}};
  localparam logic [LINE_W-1:0] Line77 = {CACHE_LINE_SIZE_BYTES{8'h77}};
  localparam logic [LINE_W-1:0] Line5A = {CACHE_LINE_SIZE_BYTES{8'h5A}};
  localparam logic [LINE_W-1:0] LineFF = {CACHE_LINE_SIZE_BYTES{8'hFF}};

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 rd_i;
  logic                 wr_i;
  logic [WORD_SIZE-1:0] addr_i;
  logic [LINE_W-1:0]    line_i;
  logic [LINE_W-1:0]    line_o;
  logic                 mem_ready_o;
  logic                 busy_o;
  logic                 err_o;

  segre_mem_responder #(
    .MEM_LATENCY   (5),
    .MEM_SIZE_LINES(256)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_i       (rd_i),
    .wr_i       (wr_i),
    .addr_i     (addr_i),
    .line_i     (line_i),
    .line_o     (line_o),
    .mem_ready_o(mem_ready_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last run() call.
  int                n_pulse;
  int                busy_cnt;
  int                b2b;
  int                pulse_at   [4];
  logic [LINE_W-1:0] pulse_line [4];
  logic              pulse_err  [4];

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request from cycle 0 through cycle hold-1, then watch ncyc cycles.
  task automatic run(input logic rd, input logic wr, input logic [WORD_SIZE-1:0] addr,
                     input logic [LINE_W-1:0] line, input int hold, input int ncyc);
    logic prev;
    rd_i     = rd;
    wr_i     = wr;
    addr_i   = addr;
    line_i   = line;
    n_pulse  = 0;
    busy_cnt = 0;
    b2b      = 0;
    prev     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse_at[i]   = 0;
      pulse_line[i] = '0;
      pulse_err[i]  = 1'b0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk_i);
      #1;
      if (k == hold) begin
        rd_i = 1'b0;
        wr_i = 1'b0;
      end
      if (busy_o) busy_cnt++;
      if (mem_ready_o) begin
        if (prev) b2b++;
        if (n_pulse < 4) begin
          pulse_at[n_pulse]   = k;
          pulse_line[n_pulse] = line_o;
          pulse_err[n_pulse]  = err_o;
        end
        n_pulse++;
      end
      prev = mem_ready_o;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i  = 1'b1;
    rd_i   = 1'b0;
    wr_i   = 1'b0;
    addr_i = '0;
    line_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ready", mem_ready_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_line", line_o, 0);
    rst_i = 1'b0;

    // Single write: pulse at cycle 5, busy through WAIT, RESP and DONE.
    run(1'b0, 1'b1, 32'h40, LineA5, 1, 8);
    check_eq("wr_npulse", n_pulse, 1);
    check_eq("wr_pulse_at", pulse_at[0], 5);
    check_eq("wr_busy_cycles", busy_cnt, 6);
    check_eq("wr_err", pulse_err[0], 0);
    check_eq("wr_line_untouched", line_o, 0);

    // Read of the same line via an unaligned address.
    run(1'b1, 1'b0, 32'h4C, '0, 1, 8);
    check_eq("rd_pulse_at", pulse_at[0], 5);
    check_eq("rd_line", pulse_line[0], LineA5);
    check_eq("rd_err", pulse_err[0], 0);
    check_eq("rd_line_held", line_o, LineA5);

    // Combined write+read: write at 5, read at 10 returning the new line.
    run(1'b1, 1'b1, 32'h80, Line3C, 1, 13);
    check_eq("rw_npulse", n_pulse, 2);
    check_eq("rw_pulse0_at", pulse_at[0], 5);
    check_eq("rw_pulse1_at", pulse_at[1], 10);
    check_eq("rw_line_hold_on_wr", pulse_line[0], LineA5);
    check_eq("rw_line_rd", pulse_line[1], Line3C);
    check_eq("rw_busy_cycles", busy_cnt, 11);

    // rd_i held 20 cycles: one request accepted every LAT+2 = 7 cycles.
    run(1'b1, 1'b0, 32'h40, '0, 20, 24);
    check_eq("hold_npulse", n_pulse, 3);
    check_eq("hold_b2b", b2b, 0);
    check_eq("hold_pulse1_at", pulse_at[1], 12);
    check_eq("hold_line", pulse_line[2], LineA5);

    // Reset during the third WAIT cycle drops the request.
    rd_i   = 1'b0;
    wr_i   = 1'b1;
    addr_i = 32'hC0;
    line_i = Line77;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1) wr_i = 1'b0;
    end
    check_eq("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("midrst_busy", busy_o, 0);
    check_eq("midrst_ready", mem_ready_o, 0);
    check_eq("midrst_line", line_o, 0);
    check_eq("midrst_err", err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run(1'b0, 1'b0, '0, '0, 1, 8);
    check_eq("postrst_npulse", n_pulse, 0);
    run(1'b1, 1'b0, 32'h40, '0, 1, 8);
    check_eq("postrst_pulse_at", pulse_at[0], 5);
    check_eq("postrst_line", pulse_line[0], LineA5);

    // Address beyond 256 lines x 16 bytes.
    run(1'b0, 1'b1, 32'h0, Line5A, 1, 8);
    run(1'b1, 1'b0, 32'h1000, '0, 1, 8);
    check_eq("oor_pulse_at", pulse_at[0], 5);
`ifdef SEGRE_MEM_RANGE_CHECK_EN
    check_eq("oor_err", pulse_err[0], 1);
    check_eq("oor_line", pulse_line[0], 0);
    check_eq("oor_err_clears", err_o, 0);
    run(1'b0, 1'b1, 32'h1000, LineFF, 1, 8);
    check_eq("oor_wr_err", pulse_err[0], 1);
    run(1'b1, 1'b0, 32'h0, '0, 1, 8);
    check_eq("oor_wr_suppressed", pulse_line[0], Line5A);
`else
    check_eq("wrap_err", pulse_err[0], 0);
    check_eq("wrap_line", pulse_line[0], Line5A);
    run(1'b0, 1'b1, 32'h1000, LineFF, 1, 8);
    run(1'b1, 1'b0, 32'h0, '0, 1, 8);
    check_eq("wrap_wr_line0", pulse_line[0], LineFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
